instr_stream_decoder: RTL and testbench

- Converts the fetch unit's variable-length instruction byte stream into one fully decoded, fixed-width instruction word.
- Sits between instruction fetch and the issue/execute stage.
- Consumes one byte per cycle through a valid/ready handshake.
- Presents one decoded instruction through a second valid/ready handshake, or signals a decode error.

---
 rtl/instr_pkg.sv | 51 +++++
 rtl/instr_stream_decoder_if.sv | 32 +++
 rtl/instr_stream_decoder_arg_assembler.sv | 59 +++++
 rtl/instr_stream_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_instr_stream_decoder.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_pkg.sv
// Shared types for the instruction stream decoder.
//   opcode_t        : 16-bit decoded opcode (short form zero-extended, word form tagged by bit 15)
//   short_op_e      : the legal short-form opcodes (0..57)
//   size_t, SZ_NONE : argument size nibble; 0..3 select 1/2/4/8 bytes, 4'hF marks an absent argument
//   decoded_instr_t : fixed-width decoded instruction,
//                     {opcode, argSize0..3, flags, arg0..arg3}
//   err_code_e      : decode error causes reported on err_code
package instr_pkg;

  localparam int ARG_W    = 64;
  localparam int NUM_ARGS = 4;
  localparam int LEN_W    = 6;   // longest instruction is 2+2+1+4*8 = 37 bytes

  typedef logic [15:0] opcode_t;

  typedef enum logic [6:0] {
    OP_NOP = 7'd0, OP_MOV, OP_LOAD, OP_STORE, OP_PUSH, OP_POP, OP_LEA, OP_XCHG,
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_NEG, OP_INC, OP_DEC,
    OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_SAR, OP_ROL,
    OP_ROR, OP_CMP, OP_TEST, OP_JMP, OP_JZ, OP_JNZ, OP_JLT, OP_JGE,
    OP_JLE, OP_JGT, OP_CALL, OP_RET, OP_LOOP, OP_IN, OP_OUT, OP_SYSCALL,
    OP_HALT, OP_WAIT, OP_FENCE, OP_CPUID, OP_RDTSC, OP_LDF, OP_STF, OP_FADD,
    OP_FSUB, OP_FMUL, OP_FDIV, OP_FSQRT, OP_CVTIF, OP_CVTFI, OP_MIN, OP_MAX,
    OP_SETF, OP_CLEARF
  } short_op_e;

  typedef logic [3:0] size_t;
  localparam size_t SZ_NONE = 4'hF;

  // Index 0 of each packed array lands in the most significant position,
  // giving the {argSize0..3} / {arg0..arg3} ordering of the output word.
  typedef struct packed {
    opcode_t                            opcode;
    size_t [0:NUM_ARGS-1]               arg_size;
    logic  [7:0]                        flags;
    logic  [0:NUM_ARGS-1][ARG_W-1:0]    arg;
  } decoded_instr_t;

  localparam int INSTR_W = $bits(decoded_instr_t);

  typedef enum logic [1:0] {
    ERR_OPCODE = 2'd0,   // short-form opcode out of range
    ERR_SIZE   = 2'd1,   // size nibble 4..14
    ERR_ORDER  = 2'd2    // present argument follows an absent one
  } err_code_e;

  function automatic logic size_legal(size_t s);
    return (s <= 4'd3) || (s == SZ_NONE);
  endfunction

endpackage

// File: rtl/instr_stream_decoder_if.sv
// Handshake bundle of the instruction stream decoder.
//   in_valid/in_ready/in_data : byte stream from fetch
//   flush                     : redirect, aborts the decode in progress
//   out_valid/out_ready       : decoded instruction handshake towards issue
//   out_instr/out_len         : decoded word and its encoded length in bytes
//   err_valid/err_code        : one-cycle decode error report
// Modport slave is the decoder's view, master is the surrounding pipeline's.
interface instr_stream_decoder_if;
  import instr_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_data;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [LEN_W-1:0]   out_len;
  logic               err_valid;
  logic [1:0]         err_code;

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_instr, out_len, err_valid, err_code
  );

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_len, err_valid, err_code
  );

endinterface

// File: rtl/instr_stream_decoder_arg_assembler.sv
// Argument assembler: collects the little-endian bytes of one argument.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : drop any partially collected argument
//   shift_en   : in_byte is an argument byte this cycle
//   in_byte    : the argument byte
//   size_log2  : argument length is 1 << size_log2 bytes
//   acc_next   : accumulator including in_byte, valid when shift_en
//   last       : in_byte completes the argument
// After the last byte the accumulator returns to zero, ready for the next
// argument, so short arguments come out zero-extended.
module arg_assembler #(
  parameter int ARG_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic [7:0]       in_byte,
  input  logic [1:0]       size_log2,
  output logic [ARG_W-1:0] acc_next,
  output logic             last
);

  logic [ARG_W-1:0] acc;
  logic [2:0]       cnt;
  logic [2:0]       last_idx;

  assign last_idx = 3'((4'd1 << size_log2) - 4'd1);
  assign last     = (cnt == last_idx);

  // Byte cnt lands in lane cnt: little-endian order.
  always_comb begin
    // NOTE: default assignment first so every path drives acc_next and no latch is inferred.
    acc_next = acc;
    for (int i = 0; i < 8; i++) begin
      if (cnt == 3'(i)) acc_next[8*i +: 8] = in_byte;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_next;
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/instr_stream_decoder.sv
// Instruction stream decoder: turns the variable-length byte stream from
// fetch into one fixed-width decoded instruction.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instr_stream_decoder_if.slave (byte input, flush,
//                decoded output, error report)
// Byte order: opcode (+ extension byte if bit 7 set), sizes 0, sizes 1,
// flags, then the present arguments. Errors are reported the cycle after
// the offending byte and the decoder restarts at the opcode byte.
module instr_stream_decoder
  import instr_pkg::*;
#(
  parameter int NUM_BYTE_OPS = int'(OP_CLEARF) + 1,
  parameter int ARG_W        = instr_pkg::ARG_W   // must match the packed output word
) (
  input logic                  clk,
  input logic                  rst_n,
  instr_stream_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    S_OP, S_OPHI, S_SZ0, S_SZ1, S_FLG, S_ARG, S_OUT
  } state_e;

  state_e         state;
  decoded_instr_t instr;
  logic [LEN_W-1:0] len;
  logic [1:0]     arg_idx;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           err_valid_q;
  err_code_e      err_code_q;

  logic             accept;
  logic             op_illegal;
  size_t            sz_lo;
  size_t            sz_hi;
  logic [1:0]       arg_idx_nxt;
  logic             args_done;
  logic [ARG_W-1:0] asm_value;
  logic             asm_last;

  assign accept      = bus.in_valid && in_ready_q;
  assign op_illegal  = !bus.in_data[7] && (int'({1'b0, bus.in_data[6:0]}) >= NUM_BYTE_OPS);
  assign sz_lo       = bus.in_data[3:0];
  assign sz_hi       = bus.in_data[7:4];
  // Order check guarantees present arguments are contiguous from arg0,
  // so the first absent one ends the argument phase.
  assign arg_idx_nxt = arg_idx + 2'd1;
  assign args_done   = (arg_idx == 2'd3) || (instr.arg_size[arg_idx_nxt] == SZ_NONE);

  arg_assembler #(.ARG_W(ARG_W)) u_arg_assembler (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (bus.flush),
    .shift_en  (accept && (state == S_ARG) && !bus.flush),
    .in_byte   (bus.in_data),
    .size_log2 (instr.arg_size[arg_idx][1:0]),
    .acc_next  (asm_value),
    .last      (asm_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the decoded word is a register bank, not a RAM, and is reset so outputs read 0 during reset.
      state       <= S_OP;
      instr       <= '0;
      len         <= '0;
      arg_idx     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_OPCODE;
    end else begin
      err_valid_q <= 1'b0;
      if (bus.flush) begin
        // Redirect wins over any byte, error or output handshake this cycle.
        state       <= S_OP;
        instr       <= '0;
        len         <= '0;
        arg_idx     <= '0;
        in_ready_q  <= 1'b1;
        out_valid_q <= 1'b0;
      end else begin
        in_ready_q <= 1'b1;
        case (state)
          S_OP: if (accept) begin
            instr   <= '0;
            len     <= LEN_W'(1);
            arg_idx <= '0;
            if (bus.in_data[7]) begin
              instr.opcode <= {1'b1, bus.in_data[6:0], 8'h00};
              state        <= S_OPHI;
            end else if (op_illegal) begin
              err_valid_q <= 1'b1;
              err_code_q  <= ERR_OPCODE;
              instr       <= '0;
              len         <= '0;
            end else begin
              instr.opcode <= {9'b0, bus.in_data[6:0]};
              state        <= S_SZ0;
            end
          end

          S_OPHI: if (accept) begin
            instr.opcode[7:0] <= bus.in_data;
            len               <= len + LEN_W'(1);
            state             <= S_SZ0;
          end

          S_SZ0: if (accept) begin
            len               <= len + LEN_W'(1);
            instr.arg_size[0] <= sz_lo;
            instr.arg_size[1] <= sz_hi;
            if (!size_legal(sz_lo) || !size_legal(sz_hi)) begin
              err_valid_q <= 1'b1;
              err_code_q  <= ERR_SIZE;
              state       <= S_OP;
              instr       <= '0;
              len         <= '0;
            end else if ((sz_lo == SZ_NONE) && (sz_hi != SZ_NONE)) begin
              err_valid_q <= 1'b1;
              err_code_q  <= ERR_ORDER;
              state       <= S_OP;
              instr       <= '0;
              len         <= '0;
            end else begin
              state <= S_SZ1;
            end
          end

          S_SZ1: if (accept) begin
            len               <= len + LEN_W'(1);
            instr.arg_size[2] <= sz_lo;
            instr.arg_size[3] <= sz_hi;
            if (!size_legal(sz_lo) || !size_legal(sz_hi)) begin
              err_valid_q <= 1'b1;
              err_code_q  <= ERR_SIZE;
              state       <= S_OP;
              instr       <= '0;
              len         <= '0;
            end else if (((instr.arg_size[1] == SZ_NONE) && (sz_lo != SZ_NONE)) ||
                         ((sz_lo == SZ_NONE) && (sz_hi != SZ_NONE))) begin
              err_valid_q <= 1'b1;
              err_code_q  <= ERR_ORDER;
              state       <= S_OP;
              instr       <= '0;
              len         <= '0;
            end else begin
              state <= S_FLG;
            end
          end

          S_FLG: if (accept) begin
            len         <= len + LEN_W'(1);
            instr.flags <= bus.in_data;
            arg_idx     <= '0;
            if (instr.arg_size[0] == SZ_NONE) begin
              state       <= S_OUT;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end else begin
              state <= S_ARG;
            end
          end

          S_ARG: if (accept) begin
            len <= len + LEN_W'(1);
            if (asm_last) begin
              instr.arg[arg_idx] <= asm_value;
              if (args_done) begin
                state       <= S_OUT;
                out_valid_q <= 1'b1;
                in_ready_q  <= 1'b0;
              end else begin
                arg_idx <= arg_idx_nxt;
              end
            end
          end

          S_OUT: begin
            if (bus.out_ready) begin
              state       <= S_OP;
              out_valid_q <= 1'b0;
            end else begin
              in_ready_q <= 1'b0;
            end
          end

          default: state <= S_OP;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = instr;
  assign bus.out_len   = len;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_instr_stream_decoder.sv
// Self-checking bench for instr_stream_decoder: directed cases followed by
// randomized instructions, all compared against a byte-stream parser model.
module tb_instr_stream_decoder;
  import instr_pkg::*;

  typedef logic [295:0] val_t;
  typedef logic [7:0]   byte_t;
  typedef byte_t        byte_q_t[$];

  typedef struct {
    bit         is_err;
    logic [1:0] err;
    int         nbytes;
    val_t       instr;
    logic [5:0] len;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_stream_decoder_if bus();

  instr_stream_decoder #(.NUM_BYTE_OPS(58), .ARG_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  bit   use_bubbles = 1'b0;
  val_t last_instr;
  val_t last_len;
  val_t last_err;

  task automatic check(input string tag, input val_t got, input val_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Parses a byte stream with the encoding rules; reports either the
  // decoded word or the error and the number of bytes up to the error.
  function automatic exp_t model(input byte_q_t b);
    exp_t        e;
    logic [15:0] op;
    logic [3:0]  sz[4];
    logic [7:0]  fl;
    logic [63:0] a[4];
    int          p;
    bit          seen_absent;
    bit          bad;
    e = '{is_err: 1'b0, err: 2'd0, nbytes: 0, instr: '0, len: 6'd0};
    for (int i = 0; i < 4; i++) a[i] = '0;
    if (b[0][7]) begin
      op = {1'b1, b[0][6:0], b[1]};
      p  = 2;
    end else begin
      op = {8'h00, b[0]};
      p  = 1;
      if (b[0] >= 8'd58) begin
        e.is_err = 1'b1; e.err = 2'd0; e.nbytes = 1;
        return e;
      end
    end
    seen_absent = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sz[2*k]   = b[p][3:0];
      sz[2*k+1] = b[p][7:4];
      p++;
      bad = 1'b0;
      for (int j = 2*k; j <= 2*k+1; j++) if (sz[j] inside {[4'd4:4'd14]}) bad = 1'b1;
      if (bad) begin
        e.is_err = 1'b1; e.err = 2'd1; e.nbytes = p;
        return e;
      end
      for (int j = 2*k; j <= 2*k+1; j++) begin
        if (sz[j] == 4'hF) seen_absent = 1'b1;
        else if (seen_absent) bad = 1'b1;
      end
      if (bad) begin
        e.is_err = 1'b1; e.err = 2'd2; e.nbytes = p;
        return e;
      end
    end
    fl = b[p];
    p++;
    for (int i = 0; i < 4; i++) begin
      if (sz[i] != 4'hF) begin
        for (int k = 0; k < (1 << sz[i]); k++) begin
          a[i][8*k +: 8] = b[p];
          p++;
        end
      end
    end
    e.nbytes = p;
    e.len    = 6'(p);
    e.instr  = {op, sz[0], sz[1], sz[2], sz[3], fl, a[0], a[1], a[2], a[3]};
    return e;
  endfunction

  function automatic byte_q_t gen_instr();
    byte_q_t    q;
    logic [3:0] sz[4];
    int         n;
    if ($urandom_range(3) == 0) begin
      q.push_back(8'($urandom) | 8'h80);
      q.push_back(8'($urandom));
    end else begin
      q.push_back(8'($urandom_range(($urandom_range(7) == 0) ? 127 : 57)));
    end
    n = $urandom_range(4);
    for (int i = 0; i < 4; i++) sz[i] = (i < n) ? 4'($urandom_range(3)) : 4'hF;
    if ($urandom_range(7) == 0) sz[$urandom_range(3)] = 4'($urandom_range(15));
    q.push_back({sz[1], sz[0]});
    q.push_back({sz[3], sz[2]});
    q.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) begin
      if (sz[i] <= 4'd3) begin
        for (int k = 0; k < (1 << sz[i]); k++) q.push_back(8'($urandom));
      end
    end
    return q;
  endfunction

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic drive_byte(input byte_t b);
    int guard;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) check("in_ready_wait", val_t'(bus.in_ready), val_t'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_instr(input byte_q_t q, input bit rdy_hi, input int hold);
    exp_t e;
    e = model(q);
    bus.out_ready = rdy_hi;
    for (int i = 0; i < e.nbytes; i++) begin
      if (use_bubbles && $urandom_range(3) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(2, 1)) @(negedge clk);
      end
      drive_byte(q[i]);
    end
    if (e.is_err) begin
      last_err = val_t'(bus.err_code);
      check("err_valid", val_t'(bus.err_valid), val_t'(1));
      check("err_code", val_t'(bus.err_code), val_t'(e.err));
      check("err_no_out_valid", val_t'(bus.out_valid), val_t'(0));
      @(negedge clk);
      check("err_pulse_end", val_t'(bus.err_valid), val_t'(0));
      check("err_in_ready", val_t'(bus.in_ready), val_t'(1));
    end else begin
      last_instr = bus.out_instr;
      last_len   = val_t'(bus.out_len);
      check("out_valid", val_t'(bus.out_valid), val_t'(1));
      check("out_instr", bus.out_instr, e.instr);
      check("out_len", val_t'(bus.out_len), val_t'(e.len));
      check("out_in_ready_low", val_t'(bus.in_ready), val_t'(0));
      check("out_no_err", val_t'(bus.err_valid), val_t'(0));
      if (!rdy_hi) begin
        repeat (hold) begin
          @(negedge clk);
          check("hold_valid", val_t'(bus.out_valid), val_t'(1));
          check("hold_instr", bus.out_instr, e.instr);
          check("hold_in_ready", val_t'(bus.in_ready), val_t'(0));
        end
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
      bus.out_ready = rdy_hi;
      check("out_valid_drop", val_t'(bus.out_valid), val_t'(0));
      check("in_ready_back", val_t'(bus.in_ready), val_t'(1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t q;
    val_t    add_exp;
    add_exp = {16'h0008, 4'h3, 4'h0, 4'hF, 4'hF, 8'h02,
               64'h1122334455667788, 64'h00000000000000AB, 64'h0, 64'h0};
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    #1;
    check("rst_in_ready", val_t'(bus.in_ready), val_t'(0));
    check("rst_out_valid", val_t'(bus.out_valid), val_t'(0));
    check("rst_err_valid", val_t'(bus.err_valid), val_t'(0));
    check("rst_out_instr", bus.out_instr, val_t'(0));
    check("rst_out_len", val_t'(bus.out_len), val_t'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_rise", val_t'(bus.in_ready), val_t'(1));

    // Short-form ADD with an 8-byte and a 1-byte argument.
    q = '{8'h08, 8'h03, 8'hFF, 8'h02, 8'h88, 8'h77, 8'h66, 8'h55,
          8'h44, 8'h33, 8'h22, 8'h11, 8'hAB};
    run_instr(q, 1'b0, 0);
    check("add_instr", last_instr, add_exp);
    check("add_len", last_len, val_t'(13));

    // NOP under back-pressure, then an immediate word-form instruction.
    q = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    run_instr(q, 1'b0, 5);
    check("nop_len", last_len, val_t'(4));
    q = '{8'h81, 8'h23, 8'hFF, 8'hFF, 8'h00};
    run_instr(q, 1'b1, 0);
    check("word_opcode", val_t'(last_instr[295:280]), val_t'(16'h8123));
    check("word_len", last_len, val_t'(5));

    // Error cases, each followed by a legal instruction.
    q = '{8'h3A};
    run_instr(q, 1'b1, 0);
    check("err_opcode", last_err, val_t'(0));
    q = '{8'h39, 8'hFF, 8'hFF, 8'h07};
    run_instr(q, 1'b1, 0);
    q = '{8'h00, 8'h05};
    run_instr(q, 1'b1, 0);
    check("err_size", last_err, val_t'(1));
    q = '{8'h01, 8'hF1, 8'hFF, 8'h00, 8'h34, 8'h12};
    run_instr(q, 1'b1, 0);
    q = '{8'h00, 8'h0F};
    run_instr(q, 1'b1, 0);
    check("err_order", last_err, val_t'(2));
    q = '{8'h02, 8'h00, 8'hF0, 8'h00, 8'h11, 8'h22, 8'h33};
    run_instr(q, 1'b1, 0);
    check("after_err_len", last_len, val_t'(7));

    // Flush after 3 of 8 arg0 bytes, with a byte offered in the flush cycle.
    q = '{8'h08, 8'hF3, 8'hFF, 8'h00, 8'hA1, 8'hA2, 8'hA3};
    foreach (q[i]) drive_byte(q[i]);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h55;
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_out_valid", val_t'(bus.out_valid), val_t'(0));
    check("flush_in_ready", val_t'(bus.in_ready), val_t'(1));
    q = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    run_instr(q, 1'b1, 0);
    check("flush_nop_len", last_len, val_t'(4));

    // Flush together with an illegal opcode byte: no error pulse.
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h3A;
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_err_suppr", val_t'(bus.err_valid), val_t'(0));
    @(negedge clk);
    check("flush_err_suppr2", val_t'(bus.err_valid), val_t'(0));

    // Flush together with the output handshake.
    q = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    bus.out_ready = 1'b0;
    foreach (q[i]) drive_byte(q[i]);
    check("pre_flush_valid", val_t'(bus.out_valid), val_t'(1));
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    check("flush_out_drop", val_t'(bus.out_valid), val_t'(0));
    check("flush_out_ready", val_t'(bus.in_ready), val_t'(1));

    // Asynchronous reset in the middle of arg0.
    q = '{8'h08, 8'h03, 8'hFF, 8'h02, 8'h88, 8'h77};
    foreach (q[i]) drive_byte(q[i]);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", val_t'(bus.out_valid), val_t'(0));
    check("arst_in_ready", val_t'(bus.in_ready), val_t'(0));
    check("arst_err_valid", val_t'(bus.err_valid), val_t'(0));
    check("arst_err_code", val_t'(bus.err_code), val_t'(0));
    check("arst_out_len", val_t'(bus.out_len), val_t'(0));
    check("arst_out_instr", bus.out_instr, val_t'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_in_ready_rise", val_t'(bus.in_ready), val_t'(1));
    q = '{8'h08, 8'h03, 8'hFF, 8'h02, 8'h88, 8'h77, 8'h66, 8'h55,
          8'h44, 8'h33, 8'h22, 8'h11, 8'hAB};
    run_instr(q, 1'b1, 0);
    check("arst_add_instr", last_instr, add_exp);

    // Randomized instructions, idle gaps and back-pressure.
    use_bubbles = 1'b1;
    for (int t = 0; t < 150; t++) begin
      q = gen_instr();
      run_instr(q, 1'($urandom_range(1)), $urandom_range(3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
